// File: rtl/led_effect_driver_if.sv
// led_effect_driver_if: control word in, LED drive and step strobe out.
// master = register side / bench, slave = led_effect_driver.
interface led_effect_driver_if;
    logic [31:0] ctrl_word;
    logic [9:0]  leds;
    logic        step_strobe;

    modport master (output ctrl_word, input leds, input step_strobe);
    modport slave  (input ctrl_word, output leds, output step_strobe);
endinterface

// File: rtl/led_effect_driver.sv
// led_effect_driver: turns the LED control word into animated effects
// (static, blink, chase, bounce) on 10 LEDs.
// Optional macro LED_PWM_EN builds the 8-bit PWM brightness gate. Without it,
// brightness is ignored and the LEDs are driven at full on.
module led_effect_driver #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned STEP_UNIT = 16
) (
    input logic                clk,
    input logic                reset_n,
    led_effect_driver_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0] STEP_U9 = 9'(STEP_UNIT);

    typedef enum logic [1:0] {ModeStatic, ModeBlink, ModeChase, ModeBounce} mode_e;

    logic [24:0]   ctrl_q, ctrl_prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    step_cnt_q, step_cnt_d, step_term;
    logic          phase_q, phase_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    pos_q, pos_d;
    logic          dir_up_q, dir_up_d;
    logic [9:0]    leds_q, raw;
    logic          strobe_q, step_evt, tick, restart, pat_chg, gate;

    logic [9:0] pattern;
    mode_e      mode;
    logic [3:0] speed;
    logic       en;

    assign pattern = ctrl_q[9:0];
    assign mode    = mode_e'(ctrl_q[11:10]);
    assign speed   = ctrl_q[15:12];
    assign en      = ctrl_q[24];

    logic unused_ctrl;
`ifdef LED_PWM_EN
    assign unused_ctrl = ^bus.ctrl_word[31:25];
    assign restart     = ctrl_q[24:10] != ctrl_prev_q[24:10];
`else
    // Brightness plays no part without the PWM stage, so it cannot restart timing.
    assign unused_ctrl = ^{bus.ctrl_word[31:25], ctrl_q[23:16], ctrl_prev_q[23:16]};
    assign restart     = {ctrl_q[24], ctrl_q[15:10]} != {ctrl_prev_q[24], ctrl_prev_q[15:10]};
`endif
    assign pat_chg   = ctrl_q[9:0] != ctrl_prev_q[9:0];
    assign step_term = (9'(speed) + 9'd1) * STEP_U9 - 9'd1;
    assign tick      = en && (presc_q == TICK_LAST);

    // Next-state for timing and effect state; restart > step > hold.
    always_comb begin
        presc_d    = presc_q;
        step_cnt_d = step_cnt_q;
        step_evt   = 1'b0;
        phase_d    = phase_q;
        frame_d    = frame_q;
        pos_d      = pos_q;
        dir_up_d   = dir_up_q;
        if (!en || restart) begin
            presc_d    = '0;
            step_cnt_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (step_cnt_q == step_term) begin
                    step_cnt_d = '0;
                    // Static has nothing to animate, so it never strobes.
                    step_evt   = (mode != ModeStatic);
                end else begin
                    step_cnt_d = step_cnt_q + 9'd1;
                end
            end
        end
        if (restart) begin
            phase_d  = 1'b0;
            frame_d  = pattern;
            pos_d    = '0;
            dir_up_d = 1'b1;
        end else begin
            // A reload wins over a coincident rotate: new pattern appears unrotated.
            if (pat_chg) begin
                frame_d = pattern;
            end else if (step_evt && mode == ModeChase) begin
                frame_d = {frame_q[8:0], frame_q[9]};
            end
            if (step_evt && mode == ModeBlink) begin
                phase_d = ~phase_q;
            end
            if (step_evt && mode == ModeBounce) begin
                if (dir_up_q) begin
                    if (pos_q == 4'd9) begin
                        pos_d    = 4'd8;
                        dir_up_d = 1'b0;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end else begin
                    if (pos_q == 4'd0) begin
                        pos_d    = 4'd1;
                        dir_up_d = 1'b1;
                    end else begin
                        pos_d = pos_q - 4'd1;
                    end
                end
            end
        end
    end

    // Raw effect from next-state values so LED changes line up with the strobe.
    always_comb begin
        raw = '0;
        case (mode)
            ModeStatic: raw = pattern;
            ModeBlink:  raw = phase_d ? '0 : pattern;
            ModeChase:  raw = frame_d;
            ModeBounce: raw = 10'd1 << pos_d;
        endcase
        if (!en) begin
            raw = '0;
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt_q;
    logic [7:0] bright;
    assign bright = ctrl_q[23:16];

    // Free-running PWM counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    // 0xFF must be solid on, which the plain compare alone cannot reach.
    assign gate = (bright == 8'hFF) || (pwm_cnt_q < bright);
`else
    assign gate = 1'b1;
`endif

    // State registers, input capture and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            ctrl_prev_q <= '0;
            presc_q     <= '0;
            step_cnt_q  <= '0;
            phase_q     <= 1'b0;
            frame_q     <= '0;
            pos_q       <= '0;
            dir_up_q    <= 1'b1;
            leds_q      <= '0;
            strobe_q    <= 1'b0;
        end else begin
            ctrl_q      <= bus.ctrl_word[24:0];
            ctrl_prev_q <= ctrl_q;
            presc_q     <= presc_d;
            step_cnt_q  <= step_cnt_d;
            phase_q     <= phase_d;
            frame_q     <= frame_d;
            pos_q       <= pos_d;
            dir_up_q    <= dir_up_d;
            leds_q      <= raw & {10{gate}};
            strobe_q    <= step_evt;
        end
    end

    assign bus.leds        = leds_q;
    assign bus.step_strobe = strobe_q;
endmodule
